esteira_lote_ctrl: RTL and testbench



---
 rtl/esteira_pkg.sv | 14 +
 rtl/esteira_belt.sv | 36 +++
 rtl/esteira_lote_ctrl.sv | 124 ++++++++++++
 tb/tb_esteira_lote_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/esteira_pkg.sv
// Shared definitions for the conveyor batch controller: FSM state encoding
// and default belt/count dimensions.
package esteira_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int BELT_LEN_DEF = 10;
    localparam int CNT_W_DEF    = 4;

endpackage

// File: rtl/esteira_belt.sv
// Belt occupancy shift register: bit 0 is the entry, bit BELT_LEN-1 the exit.
// EXIT_BIT is the product about to fall off the end on the next shift.
module esteira_belt
    import esteira_pkg::*;
#(
    parameter int BELT_LEN = BELT_LEN_DEF
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                SHIFT_EN,
    input  logic                PROD,
    output logic [BELT_LEN-1:0] LEDS,
    output logic                EXIT_BIT
);

    logic [BELT_LEN-1:0] leds_q, leds_d;

    always_comb begin
        leds_d = leds_q;
        if (SHIFT_EN) begin
            leds_d = {leds_q[BELT_LEN-2:0], PROD};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            leds_q <= '0;
        end else begin
            leds_q <= leds_d;
        end
    end

    assign LEDS     = leds_q;
    assign EXIT_BIT = leds_q[BELT_LEN-1];

endmodule

// File: rtl/esteira_lote_ctrl.sv
// Conveyor batch controller: counts products leaving the belt against a loaded
// target, stops at completion and waits for ACK. Optional BATCHES output under
// macro ESTEIRA_BATCH_CNT_EN.
module esteira_lote_ctrl
    import esteira_pkg::*;
#(
    parameter int BELT_LEN = BELT_LEN_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [CNT_W-1:0]    TARGET,
    input  logic                REG,
    input  logic                PROD,
    input  logic                STEP,
    input  logic                ACK,
    output logic [BELT_LEN-1:0] LEDS,
    output logic [CNT_W-1:0]    COUNT,
    output logic [CNT_W-1:0]    TARGET_Q,
    output logic                BUSY,
    output logic                FIM
`ifdef ESTEIRA_BATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]    BATCHES
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W:0]   count_inc;
    logic             shift_en;
    logic             exit_bit;
    logic             done_hit;

    esteira_belt #(
        .BELT_LEN(BELT_LEN)
    ) u_belt (
        .CLK     (CLK),
        .RESET   (RESET),
        .SHIFT_EN(shift_en),
        .PROD    (PROD),
        .LEDS    (LEDS),
        .EXIT_BIT(exit_bit)
    );

    // One extra bit so the completion compare cannot alias on a wrapped count.
    assign count_inc = {1'b0, count_q} + (CNT_W+1)'(1);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        target_d = target_q;
        shift_en = 1'b0;
        done_hit = 1'b0;
        if (REG && (TARGET != '0)) begin
            target_d = TARGET;
            count_d  = '0;
            state_d  = RUN;
        end else begin
            case (state_q)
                IDLE: ;
                RUN: begin
                    if (STEP) begin
                        shift_en = 1'b1;
                        if (exit_bit) begin
                            count_d = count_inc[CNT_W-1:0];
                            if (count_inc == {1'b0, target_q}) begin
                                state_d  = DONE;
                                done_hit = 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (ACK) begin
                        count_d = '0;
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            count_q  <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            target_q <= target_d;
        end
    end

`ifdef ESTEIRA_BATCH_CNT_EN
    logic [CNT_W-1:0] batches_q, batches_d;

    always_comb begin
        batches_d = batches_q;
        if (done_hit) begin
            batches_d = batches_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            batches_q <= '0;
        end else begin
            batches_q <= batches_d;
        end
    end

    assign BATCHES = batches_q;
`endif

    assign COUNT    = count_q;
    assign TARGET_Q = target_q;
    assign BUSY     = (state_q == RUN);
    assign FIM      = (state_q == DONE);

endmodule

// File: tb/tb_esteira_lote_ctrl.sv
// Self-checking bench for esteira_lote_ctrl: directed vector table, corner
// sequences and randomized traffic against a behavioural belt/batch model.
module tb_esteira_lote_ctrl;

    localparam int BL = 10;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0, reg_s = 1'b0, prod = 1'b0, step = 1'b0, ack = 1'b0;
    logic [CW-1:0] tgt = '0;
    logic [BL-1:0] leds;
    logic [CW-1:0] count, target_q;
    logic          busy, fim;
`ifdef ESTEIRA_BATCH_CNT_EN
    logic [CW-1:0] batches;
`endif

    always #5 clk = ~clk;

    esteira_lote_ctrl #(.BELT_LEN(BL), .CNT_W(CW)) dut (
        .CLK     (clk),
        .RESET   (rst),
        .TARGET  (tgt),
        .REG     (reg_s),
        .PROD    (prod),
        .STEP    (step),
        .ACK     (ack),
        .LEDS    (leds),
        .COUNT   (count),
        .TARGET_Q(target_q),
        .BUSY    (busy),
        .FIM     (fim)
`ifdef ESTEIRA_BATCH_CNT_EN
        ,
        .BATCHES (batches)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural model: belt as an array of slots, mode 0=idle 1=running 2=finished
    int m_belt[BL];
    int m_mode, m_count, m_target, m_batches;

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0d: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic model_step(bit r, bit g, logic [CW-1:0] t, bit p, bit s, bit a);
        int out;
        if (r) begin
            foreach (m_belt[i]) m_belt[i] = 0;
            m_mode = 0; m_count = 0; m_target = 0; m_batches = 0;
        end else if (g && t != 0) begin
            m_target = int'(t); m_count = 0; m_mode = 1;
        end else if (m_mode == 2 && a) begin
            m_count = 0; m_mode = 1;
        end else if (m_mode == 1 && s) begin
            out = m_belt[BL-1];
            for (int i = BL-1; i > 0; i--) m_belt[i] = m_belt[i-1];
            m_belt[0] = p ? 1 : 0;
            if (out != 0) begin
                m_count = m_count + 1;
                if (m_count == m_target) begin
                    m_mode = 2;
                    m_batches = (m_batches + 1) % (1 << CW);
                end
            end
        end
    endtask

    task automatic model_check();
        logic [31:0] e;
        e = '0;
        for (int i = 0; i < BL; i++) e[i] = (m_belt[i] != 0);
        chk("m_leds", cyc, 32'(leds), e);
        chk("m_count", cyc, 32'(count), 32'(m_count));
        chk("m_target", cyc, 32'(target_q), 32'(m_target));
        chk("m_busy", cyc, 32'(busy), 32'(m_mode == 1));
        chk("m_fim", cyc, 32'(fim), 32'(m_mode == 2));
`ifdef ESTEIRA_BATCH_CNT_EN
        chk("m_batches", cyc, 32'(batches), 32'(m_batches));
`endif
    endtask

    task automatic cycle(bit r, bit g, logic [CW-1:0] t, bit p, bit s, bit a);
        rst = r; reg_s = g; tgt = t; prod = p; step = s; ack = a;
        @(posedge clk);
        model_step(r, g, t, p, s, a);
        #1;
        cyc++;
        model_check();
    endtask

    typedef struct {
        bit            r, g;
        logic [CW-1:0] t;
        bit            p, s, a;
        logic [BL-1:0] leds;
        logic [CW-1:0] cnt, tq;
        bit            busy, fim;
    } vec_t;

    vec_t tbl[$];

    task automatic add(bit r, bit g, logic [CW-1:0] t, bit p, bit s, bit a,
                       logic [BL-1:0] l, logic [CW-1:0] c, logic [CW-1:0] q, bit b, bit f);
        vec_t v;
        v.r = r; v.g = g; v.t = t; v.p = p; v.s = s; v.a = a;
        v.leds = l; v.cnt = c; v.tq = q; v.busy = b; v.fim = f;
        tbl.push_back(v);
    endtask

    initial begin
        //   r g  t  p s a   leds    cnt tq busy fim
        add(1, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0);
        add(0, 1, 3, 0, 0, 0, 10'h000, 0, 3, 1, 0);
        add(0, 1, 2, 0, 0, 0, 10'h000, 0, 2, 1, 0);
        add(0, 0, 0, 1, 1, 0, 10'h001, 0, 2, 1, 0);
        add(0, 0, 0, 1, 1, 0, 10'h003, 0, 2, 1, 0);
        add(0, 0, 0, 0, 1, 0, 10'h006, 0, 2, 1, 0);
        add(0, 0, 0, 0, 1, 0, 10'h00C, 0, 2, 1, 0);
        add(0, 0, 0, 0, 1, 0, 10'h018, 0, 2, 1, 0);
        add(0, 0, 0, 0, 1, 0, 10'h030, 0, 2, 1, 0);
        add(0, 0, 0, 0, 1, 0, 10'h060, 0, 2, 1, 0);
        add(0, 0, 0, 0, 1, 0, 10'h0C0, 0, 2, 1, 0);
        add(0, 0, 0, 0, 1, 0, 10'h180, 0, 2, 1, 0);
        add(0, 0, 0, 0, 1, 0, 10'h300, 0, 2, 1, 0);
        add(0, 0, 0, 0, 1, 0, 10'h200, 1, 2, 1, 0);
        add(0, 0, 0, 1, 1, 0, 10'h001, 2, 2, 0, 1);
        add(0, 0, 0, 1, 1, 0, 10'h001, 2, 2, 0, 1);
        add(0, 0, 0, 1, 1, 0, 10'h001, 2, 2, 0, 1);
        add(0, 0, 0, 1, 1, 0, 10'h001, 2, 2, 0, 1);
        add(0, 0, 0, 0, 0, 1, 10'h001, 0, 2, 1, 0);
        add(0, 1, 5, 1, 1, 0, 10'h001, 0, 5, 1, 0);
        add(0, 0, 0, 0, 1, 0, 10'h002, 0, 5, 1, 0);
        add(0, 0, 0, 0, 0, 1, 10'h002, 0, 5, 1, 0);
        add(0, 0, 0, 1, 0, 0, 10'h002, 0, 5, 1, 0);
        add(0, 1, 0, 1, 1, 0, 10'h005, 0, 5, 1, 0);
        add(1, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 10'h000, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 10'h000, 0, 0, 0, 0);

        foreach (m_belt[i]) m_belt[i] = 0;
        m_mode = 0; m_count = 0; m_target = 0; m_batches = 0;

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].r, tbl[i].g, tbl[i].t, tbl[i].p, tbl[i].s, tbl[i].a);
            chk("tbl_leds", i, 32'(leds), 32'(tbl[i].leds));
            chk("tbl_count", i, 32'(count), 32'(tbl[i].cnt));
            chk("tbl_target", i, 32'(target_q), 32'(tbl[i].tq));
            chk("tbl_busy", i, 32'(busy), 32'(tbl[i].busy));
            chk("tbl_fim", i, 32'(fim), 32'(tbl[i].fim));
        end

        // Reset mid-batch with a full belt and a partial count
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 15, 0, 0, 0);
        for (int k = 0; k < BL + 3; k++) cycle(0, 0, 0, 1, 1, 0);
        chk("mid_leds_full", 0, 32'(leds), 32'h3FF);
        chk("mid_count3", 0, 32'(count), 32'd3);
        cycle(1, 0, 0, 0, 0, 0);
        chk("mid_rst_leds", 0, 32'(leds), 32'h0);
        chk("mid_rst_count", 0, 32'(count), 32'h0);
        chk("mid_rst_tq", 0, 32'(target_q), 32'h0);
        chk("mid_rst_busy", 0, 32'(busy), 32'h0);

        // ACK together with STEP in DONE drops the step
        cycle(0, 1, 1, 0, 0, 0);
        for (int k = 0; k < BL; k++) cycle(0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("ackstep_fim", 0, 32'(fim), 32'h1);
        chk("ackstep_leds0", 0, 32'(leds), 32'h3FE);
        cycle(0, 0, 0, 1, 1, 1);
        chk("ackstep_busy", 0, 32'(busy), 32'h1);
        chk("ackstep_leds1", 0, 32'(leds), 32'h3FE);
        chk("ackstep_count", 0, 32'(count), 32'h0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("ackstep_leds2", 0, 32'(leds), 32'h3FC);
        chk("ackstep_refim", 0, 32'(fim), 32'h1);

`ifdef ESTEIRA_BATCH_CNT_EN
        cycle(1, 0, 0, 0, 0, 0);
        chk("batch_rst", 0, 32'(batches), 32'h0);
        cycle(0, 1, 1, 0, 0, 0);
        for (int b = 0; b < 17; b++) begin
            for (int k = 0; k < 20 && !fim; k++) cycle(0, 0, 0, 1, 1, 0);
            chk("batch_fim", b, 32'(fim), 32'h1);
            cycle(0, 0, 0, 0, 0, 1);
        end
        chk("batch_wrap", 0, 32'(batches), 32'h1);
`endif

        // Randomized traffic checked against the model every cycle
        cycle(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            bit            r, g, p, s, a;
            logic [CW-1:0] t;
            r = ($urandom_range(0, 199) == 0);
            g = ($urandom_range(0, 24) == 0);
            t = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 15)) : CW'($urandom_range(0, 3));
            p = ($urandom_range(0, 1) == 1);
            s = ($urandom_range(0, 1) == 1);
            a = ($urandom_range(0, 5) == 0);
            cycle(r, g, t, p, s, a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
